// File: rtl/iic_reg_write_seq_pkg.sv
// Shared definitions for the IIC register-write sequencer: FSM encoding,
// byte-slot indices and the byte mux used to build each outgoing byte.
package iic_reg_write_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_GAP   = 3'd4,
    ST_FIN   = 3'd5,
    ST_FAIL  = 3'd6
  } seq_state_e;

  localparam logic [1:0] BYTE_DEV = 2'd0;
  localparam logic [1:0] BYTE_REG = 2'd1;
  localparam logic [1:0] BYTE_DAT = 2'd2;

  localparam logic RW_WRITE = 1'b0;

  function automatic logic [7:0] sel_byte(input logic [1:0] idx,
                                          input logic [6:0] dev,
                                          input logic [7:0] regad,
                                          input logic [7:0] dat);
    logic [7:0] b;
    case (idx)
      BYTE_DEV: b = {dev, RW_WRITE};
      BYTE_REG: b = regad;
      default:  b = dat;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/iic_reg_write_seq_if.sv
// Host request/status and byte-writer handshake of the register-write sequencer.
interface iic_reg_write_seq_if;
  // Host side: req is taken only while busy=0 and never queued; done (with err
  // on timeout) pulses for one cycle. Writer side: wr_en pulses once per byte,
  // wr_data holds until the writer's one-cycle byte_done.
  logic       req;
  logic [6:0] dev_addr;
  logic [7:0] reg_addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic       err;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       byte_done;
  logic [1:0] byte_idx;

  modport master (
    output req, dev_addr, reg_addr, wdata, byte_done,
    input  busy, done, err, wr_en, wr_data, byte_idx
  );

  modport slave (
    input  req, dev_addr, reg_addr, wdata, byte_done,
    output busy, done, err, wr_en, wr_data, byte_idx
  );
endinterface

// File: rtl/iic_reg_write_seq.sv
// Feeds one IIC register write ({dev,W}, reg, data) to a single-byte writer,
// with an inter-byte gap and a per-byte done timeout.
module iic_reg_write_seq
  import iic_reg_write_seq_pkg::*;
#(
  parameter int GAP_CYC     = 10,
  parameter int TIMEOUT_CYC = 2000,
  parameter int CNT_W       = 12
) (
  input  logic                clk,
  input  logic                rst,
  iic_reg_write_seq_if.slave  bus,
  output seq_state_e          state_o
);

  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [6:0]       dev_q, dev_d;
  logic [7:0]       reg_q, reg_d;
  logic [7:0]       dat_q, dat_d;
  logic [7:0]       wr_data_q, wr_data_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= BYTE_DEV;
      dev_q     <= '0;
      reg_q     <= '0;
      dat_q     <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      dev_q     <= dev_d;
      reg_q     <= reg_d;
      dat_q     <= dat_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    dev_d     = dev_q;
    reg_d     = reg_q;
    dat_d     = dat_q;
    wr_data_d = wr_data_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          dev_d   = bus.dev_addr;
          reg_d   = bus.reg_addr;
          dat_d   = bus.wdata;
          idx_d   = BYTE_DEV;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        wr_data_d = sel_byte(idx_q, dev_q, reg_q, dat_q);
        state_d   = ST_ISSUE;
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A done arriving on the last allowed cycle still counts as success.
        if (bus.byte_done) begin
          cnt_d = '0;
          if (idx_q == BYTE_DAT) begin
            state_d = ST_FIN;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = ST_GAP;
          end
        end else if (cnt_q == TO_LAST) begin
          state_d = ST_FAIL;
        end
      end
      ST_GAP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == GAP_LAST) begin
          state_d = ST_LOAD;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      ST_FAIL: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = (state_q == ST_FIN) || (state_q == ST_FAIL);
  assign bus.err      = (state_q == ST_FAIL);
  assign bus.wr_en    = (state_q == ST_ISSUE);
  assign bus.wr_data  = wr_data_q;
  assign bus.byte_idx = idx_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_iic_reg_write_seq.sv
// Directed bench for iic_reg_write_seq with a delayed byte_done stub.
module tb_iic_reg_write_seq;
  import iic_reg_write_seq_pkg::*;

  localparam int GAP_CYC     = 10;
  localparam int TIMEOUT_CYC = 2000;
  localparam int CNT_W       = 12;

  logic       clk = 1'b0;
  logic       rst;
  seq_state_e state;
  int         cyc = 0;

  iic_reg_write_seq_if bus();

  iic_reg_write_seq #(
    .GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .state_o(state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  int chk_cnt = 0;
  int err_cnt = 0;

  logic [9:0] exp_q[$];
  int         wen_cyc[$];
  int         done_cnt = 0;
  int         done_cyc = 0;
  logic       last_err = 1'b0;
  logic [1:0] last_idx = 2'd0;
  int         req_cyc = 0;

  int stub_dly[3] = '{20, 20, 20};
  int stub_mute   = -1;
  int stub_cnt    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // byte writer stub: one-cycle byte_done stub_dly[idx] cycles after wr_en
  initial begin
    bus.byte_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.byte_done = 1'b0;
      if (rst) begin
        stub_cnt = 0;
      end else begin
        if (stub_cnt > 0) begin
          stub_cnt--;
          if (stub_cnt == 0) bus.byte_done = 1'b1;
        end
        if (bus.wr_en && int'(bus.byte_idx) != stub_mute)
          stub_cnt = stub_dly[bus.byte_idx];
      end
    end
  end

  // monitor / scoreboard
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (!rst && bus.wr_en) begin
        wen_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("exp_avail_at_wr_en", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("wr_data", bus.wr_data, e[7:0]);
          check("byte_idx", bus.byte_idx, e[9:8]);
        end
      end
      if (!rst && bus.err && !bus.done) check("err_implies_done", bus.done, 1);
      if (!rst && bus.done) begin
        done_cnt++;
        done_cyc = cyc;
        last_err = bus.err;
        last_idx = bus.byte_idx;
      end
    end
  end

  task automatic start_req(input logic [6:0] d, input logic [7:0] r,
                           input logic [7:0] w, input bit push);
    @(posedge clk); #1;
    bus.req      = 1'b1;
    bus.dev_addr = d;
    bus.reg_addr = r;
    bus.wdata    = w;
    req_cyc      = cyc;
    if (push) begin
      exp_q.push_back({BYTE_DEV, d, 1'b0});
      exp_q.push_back({BYTE_REG, r});
      exp_q.push_back({BYTE_DAT, w});
    end
    @(posedge clk); #1;
    bus.req      = 1'b0;
    bus.dev_addr = 7'($urandom_range(0, 127));
    bus.reg_addr = 8'($urandom_range(0, 255));
    bus.wdata    = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_done(input string tag, input int budget);
    int start = done_cnt;
    int n = 0;
    while (done_cnt == start && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, done_cnt != start, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int base;
    int n;
    rst = 1'b1;
    bus.req = 1'b0;
    bus.dev_addr = '0;
    bus.reg_addr = '0;
    bus.wdata = '0;
    idle(3);
    check("rst_state", state, ST_IDLE);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_wr_data", bus.wr_data, 8'h00);
    check("rst_byte_idx", bus.byte_idx, 0);
    rst = 1'b0;
    idle(2);

    // nominal write, 20-cycle writer
    wen_cyc.delete();
    base = done_cnt;
    start_req(7'h50, 8'h10, 8'hA5, 1'b1);
    wait_done("nom_done_seen", 400);
    check("nom_busy_after_done", bus.busy, 0);
    check("nom_err", last_err, 0);
    check("nom_wr_en_count", wen_cyc.size(), 3);
    check("nom_exp_empty", exp_q.size(), 0);
    if (wen_cyc.size() == 3) begin
      check("nom_req_to_wr_en", wen_cyc[0] - req_cyc, 2);
      check("nom_spacing_01", wen_cyc[1] - wen_cyc[0], 20 + GAP_CYC + 2);
      check("nom_spacing_12", wen_cyc[2] - wen_cyc[1], 20 + GAP_CYC + 2);
      check("nom_last_done_to_done", done_cyc - wen_cyc[2], 21);
    end
    check("nom_wr_data_hold", bus.wr_data, 8'hA5);
    idle(5);
    check("nom_single_done", done_cnt - base, 1);

    // timeout on second byte
    wen_cyc.delete();
    stub_mute = 1;
    base = done_cnt;
    start_req(7'h21, 8'h33, 8'h44, 1'b0);
    exp_q.push_back({BYTE_DEV, 7'h21, 1'b0});
    exp_q.push_back({BYTE_REG, 8'h33});
    wait_done("to_done_seen", TIMEOUT_CYC + 200);
    check("to_err", last_err, 1);
    check("to_byte_idx", last_idx, 1);
    check("to_wr_en_count", wen_cyc.size(), 2);
    if (wen_cyc.size() == 2)
      check("to_latency", done_cyc - wen_cyc[1], TIMEOUT_CYC + 1);
    check("to_state_idle", state, ST_IDLE);
    idle(5);
    check("to_single_done", done_cnt - base, 1);
    stub_mute = -1;

    // req while busy is ignored
    wen_cyc.delete();
    stub_dly = '{8, 8, 8};
    base = done_cnt;
    start_req(7'h1A, 8'hC0, 8'h5E, 1'b1);
    idle(4);
    start_req(7'h7F, 8'hEE, 8'h11, 1'b0);
    idle(20);
    start_req(7'h05, 8'h06, 8'h07, 1'b0);
    wait_done("rb_done_seen", 400);
    check("rb_err", last_err, 0);
    idle(10);
    check("rb_single_done", done_cnt - base, 1);
    check("rb_wr_en_count", wen_cyc.size(), 3);
    check("rb_exp_empty", exp_q.size(), 0);

    // byte_done on the last allowed cycle wins over timeout
    wen_cyc.delete();
    stub_dly = '{3, 3, TIMEOUT_CYC};
    start_req(7'h2B, 8'h9C, 8'h3D, 1'b1);
    wait_done("sim_done_seen", TIMEOUT_CYC + 400);
    check("sim_err", last_err, 0);
    if (wen_cyc.size() == 3)
      check("sim_latency", done_cyc - wen_cyc[2], TIMEOUT_CYC + 1);
    check("sim_exp_empty", exp_q.size(), 0);

    // reset during the gap after byte 0
    wen_cyc.delete();
    stub_dly = '{20, 20, 20};
    base = done_cnt;
    start_req(7'h44, 8'h55, 8'h66, 1'b1);
    n = 0;
    while (wen_cyc.size() < 1 && n < 50) begin @(posedge clk); #1; n++; end
    check("rs_first_wr_en", wen_cyc.size(), 1);
    idle(23);
    check("rs_in_gap", state, ST_GAP);
    rst = 1'b1;
    #1;
    check("rs_state", state, ST_IDLE);
    check("rs_busy", bus.busy, 0);
    check("rs_done", bus.done, 0);
    check("rs_err", bus.err, 0);
    check("rs_wr_en", bus.wr_en, 0);
    check("rs_wr_data", bus.wr_data, 8'h00);
    check("rs_byte_idx", bus.byte_idx, 0);
    idle(3);
    rst = 1'b0;
    check("rs_no_done", done_cnt - base, 0);
    exp_q.delete();
    wen_cyc.delete();
    idle(2);
    start_req(7'h3C, 8'h00, 8'hFF, 1'b1);
    wait_done("rs_new_done_seen", 400);
    check("rs_new_err", last_err, 0);
    check("rs_new_wr_en_count", wen_cyc.size(), 3);
    check("rs_new_exp_empty", exp_q.size(), 0);
    idle(5);
    check("rs_single_done", done_cnt - base, 1);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
